// File: rtl/local_buffer_arbiter_pkg.sv
// Shared constants and helpers for the local buffer arbiter slice.
// Optional perf counters are enabled with LBUF_ARB_PERF_EN.
package local_buffer_arbiter_pkg;

    localparam int LBUF_ADDR_W  = 10;
    localparam int LBUF_DATA_W  = 16;
    localparam int LBUF_NUM_REQ = 4;
    localparam int LBUF_ID_W    = $clog2(LBUF_NUM_REQ);
    localparam int PERF_W       = 32;

    function automatic logic [PERF_W-1:0] sat_inc(
        input logic [PERF_W-1:0] c
    );
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/local_buffer_arbiter_if.sv
// Requester-side bus of the local buffer arbiter.
// slave = arbiter side, master = requester side.
interface local_buffer_arbiter_if
    import local_buffer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = LBUF_NUM_REQ,
    parameter int ADDR_W  = LBUF_ADDR_W,
    parameter int DATA_W  = LBUF_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_lock,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );

    modport master (
        output req_valid,
        output req_we,
        output req_lock,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

endinterface

// File: rtl/local_buffer_arbiter_rr_priority_pick.sv
// Rotate-priority find-first: first set bit of valid
// scanning ptr, ptr+1, ... modulo N.
module rr_priority_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    valid,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx
);

    always_comb begin : pick
        logic found;
        int   j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/local_buffer_arbiter.sv
// Round-robin arbiter sharing one single-port local buffer.
// Define LBUF_ARB_PERF_EN to add busy/conflict perf counters.
module local_buffer_arbiter
    import local_buffer_arbiter_pkg::*;
#(
    parameter int NUM_REQ = LBUF_NUM_REQ,
    parameter int ADDR_W  = LBUF_ADDR_W,
    parameter int DATA_W  = LBUF_DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    local_buffer_arbiter_if.slave req_if,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef LBUF_ARB_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [PERF_W-1:0] perf_busy_cnt,
    output logic [PERF_W-1:0] perf_conflict_cnt
`endif
);

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    lock_id;
    logic [ID_W-1:0]    rd_id;
    logic [ID_W-1:0]    pick_idx;
    logic [ID_W-1:0]    g;
    logic [ID_W-1:0]    g_next;
    logic               lock_vld;
    logic               rd_pend;
    logic               xfer;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] lock_oh;

    rr_priority_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .valid (req_if.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_gnt),
        .idx   (pick_idx)
    );

    assign lock_oh = NUM_REQ'(1) << lock_id;

    // A held lock bypasses round-robin entirely, even if the owner is idle.
    always_comb begin
        gnt = pick_gnt;
        g   = pick_idx;
        if (lock_vld) begin
            gnt = lock_oh & req_if.req_valid;
            g   = lock_id;
        end
    end

    assign xfer             = |gnt;
    assign req_if.req_ready = gnt;
    assign g_next           = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;

    assign mem_ce    = xfer;
    assign mem_we    = xfer & req_if.req_we[g];
    assign mem_addr  = req_if.req_addr[g*ADDR_W +: ADDR_W];
    assign mem_wdata = req_if.req_wdata[g*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            lock_vld <= 1'b0;
            lock_id  <= '0;
            rd_pend  <= 1'b0;
            rd_id    <= '0;
        end else begin
            rd_pend <= xfer & ~mem_we;
            if (xfer) begin
                rd_id <= g;
                if (req_if.req_lock[g]) begin
                    lock_vld <= 1'b1;
                    lock_id  <= g;
                end else begin
                    lock_vld <= 1'b0;
                    rr_ptr   <= g_next;
                end
            end
        end
    end

    assign req_if.rsp_valid = rd_pend ? (NUM_REQ'(1) << rd_id) : '0;
    assign req_if.rsp_rdata = mem_rdata;

`ifdef LBUF_ARB_PERF_EN
    logic conflict;

    assign conflict = ($countones(req_if.req_valid) > 1)
                    | (lock_vld & |(req_if.req_valid & ~lock_oh));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cnt     <= '0;
            perf_conflict_cnt <= '0;
        end else if (perf_clr) begin
            perf_busy_cnt     <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (mem_ce)
                perf_busy_cnt <= sat_inc(perf_busy_cnt);
            if (conflict)
                perf_conflict_cnt <= sat_inc(perf_conflict_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_local_buffer_arbiter.sv
// Scoreboard bench for local_buffer_arbiter with a behavioural buffer.
// Perf counter checks are built when LBUF_ARB_PERF_EN is defined.
module tb_local_buffer_arbiter;
    import local_buffer_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 16;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_chk = 0;
    int n_fail = 0;

`ifdef LBUF_ARB_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] perf_busy_cnt;
    logic [31:0] perf_conflict_cnt;
`endif

    always #5 clk = ~clk;

    local_buffer_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    local_buffer_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_if    (bus),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef LBUF_ARB_PERF_EN
        ,
        .perf_clr          (perf_clr),
        .perf_busy_cnt     (perf_busy_cnt),
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    // Single-port buffer with registered read.
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            else
                mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input int i, input logic v, input logic we,
                       input logic lk, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        bus.req_valid[i]          = v;
        bus.req_we[i]             = we;
        bus.req_lock[i]           = lk;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) drv(i, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic exp_g(input int id, input logic [AW-1:0] a,
                         input logic we, input logic [DW-1:0] d);
        gnt_t e;
        e.id = id; e.addr = a; e.we = we; e.wdata = d;
        gq.push_back(e);
    endtask

    task automatic exp_r(input int id, input logic [DW-1:0] d);
        rsp_t e;
        e.id = id; e.data = d;
        rq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every grant and response against the queues.
    always @(negedge clk) begin : monitor
        gnt_t e;
        rsp_t r;
        if (rst_n) begin
            if (|bus.req_ready) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 32'(bus.req_ready), 32'h0);
                end else begin
                    e = gq.pop_front();
                    chk("grant", 32'(bus.req_ready), 32'(1) << e.id);
                    chk("mem_ce", 32'(mem_ce), 32'h1);
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we)
                        chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                end
            end else begin
                chk("mem_ce_idle", 32'(mem_ce), 32'h0);
            end
            if (|bus.rsp_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
                end else begin
                    r = rq.pop_front();
                    chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << r.id);
                    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(r.data));
                end
            end
        end
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(16'h1000 + a);
        idle_all();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'h0);
        chk("reset_mem_ce", 32'(mem_ce), 32'h0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        step();

        // All four read; rotation 0,1,2,3,0.
        for (int i = 0; i < N; i++) drv(i, 1'b1, 1'b0, 1'b0, AW'(10'h010 + i), '0);
        exp_g(0, 10'h010, 1'b0, '0); exp_r(0, 16'h1010);
        exp_g(1, 10'h011, 1'b0, '0); exp_r(1, 16'h1011);
        exp_g(2, 10'h012, 1'b0, '0); exp_r(2, 16'h1012);
        exp_g(3, 10'h013, 1'b0, '0); exp_r(3, 16'h1013);
        exp_g(0, 10'h010, 1'b0, '0); exp_r(0, 16'h1010);
        repeat (5) step();
        idle_all();
        step();

        // Write then read-after-write from another requester.
        drv(1, 1'b1, 1'b1, 1'b0, 10'h3FF, 16'hBEEF);
        exp_g(1, 10'h3FF, 1'b1, 16'hBEEF);
        step();
        drv(1, 1'b0, 1'b0, 1'b0, '0, '0);
        drv(2, 1'b1, 1'b0, 1'b0, 10'h3FF, '0);
        exp_g(2, 10'h3FF, 1'b0, '0); exp_r(2, 16'hBEEF);
        step();
        idle_all();
        step();

        // Locked burst from requester 3, then rr wraps to 0.
        drv(0, 1'b1, 1'b0, 1'b0, 10'h020, '0);
        drv(1, 1'b1, 1'b0, 1'b0, 10'h021, '0);
        for (int k = 0; k < 4; k++) begin
            drv(3, 1'b1, 1'b1, (k < 3), AW'(10'h100 + k), DW'(16'hA000 + k));
            exp_g(3, AW'(10'h100 + k), 1'b1, DW'(16'hA000 + k));
            step();
        end
        drv(3, 1'b0, 1'b0, 1'b0, '0, '0);
        exp_g(0, 10'h020, 1'b0, '0); exp_r(0, 16'h1020);
        step();
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
        exp_g(1, 10'h021, 1'b0, '0); exp_r(1, 16'h1021);
        step();
        drv(1, 1'b0, 1'b0, 1'b0, '0, '0);
        drv(2, 1'b1, 1'b0, 1'b0, 10'h102, '0);
        exp_g(2, 10'h102, 1'b0, '0); exp_r(2, 16'hA002);
        step();
        idle_all();
        step();

        // Read in flight when reset hits: response is dropped.
        drv(2, 1'b1, 1'b0, 1'b0, 10'h3FF, '0);
        exp_g(2, 10'h3FF, 1'b0, '0);
        step();
        idle_all();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rsp_in_reset", 32'(bus.rsp_valid), 32'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rsp_after_reset", 32'(bus.rsp_valid), 32'h0);
        chk("ready_after_reset", 32'(bus.req_ready), 32'h0);
        step();
        // rr_ptr back at 0: requester 0 wins over 3.
        drv(0, 1'b1, 1'b0, 1'b0, 10'h010, '0);
        drv(3, 1'b1, 1'b0, 1'b0, 10'h013, '0);
        exp_g(0, 10'h010, 1'b0, '0); exp_r(0, 16'h1010);
        step();
        drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
        exp_g(3, 10'h013, 1'b0, '0); exp_r(3, 16'h1013);
        step();
        idle_all();
        step();

`ifdef LBUF_ARB_PERF_EN
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        drv(0, 1'b1, 1'b1, 1'b0, 10'h200, 16'h5555);
        drv(1, 1'b1, 1'b1, 1'b0, 10'h201, 16'hAAAA);
        for (int k = 0; k < 5; k++) begin
            exp_g(0, 10'h200, 1'b1, 16'h5555);
            exp_g(1, 10'h201, 1'b1, 16'hAAAA);
        end
        repeat (10) step();
        idle_all();
        @(negedge clk);
        chk("perf_busy", perf_busy_cnt, 32'd10);
        chk("perf_conflict", perf_conflict_cnt, 32'd10);
        step();
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        @(negedge clk);
        chk("perf_busy_clr", perf_busy_cnt, 32'd0);
        chk("perf_conflict_clr", perf_conflict_cnt, 32'd0);
        step();
`endif

        repeat (3) step();
        chk("grants_left", 32'(gq.size()), 32'h0);
        chk("rsps_left", 32'(rq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
